mult_div: RTL and testbench

//  Iterative multiply/divide unit that owns the HI/LO register pair for the MIPS core.
//  It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, which the combinational ALU does not handle.

---
 rtl/mult_div_if.sv | 32 +++
 rtl/mult_div.sv | 146 ++++++++++++++
 tb/tb_mult_div.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_if
//  Description : Request/result bundle between execute-stage control and the
//                iterative multiply/divide unit that owns HI/LO.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_div_if #(
    parameter int DATA_W = 32
);
    logic              start_md_i;
    logic [2:0]        op_md_i;
    logic [DATA_W-1:0] opr_a_md_i;
    logic [DATA_W-1:0] opr_b_md_i;
    logic              busy_md_o;
    logic              done_md_o;
    logic [DATA_W-1:0] hi_md_o;
    logic [DATA_W-1:0] lo_md_o;

    // Control side: issues ops, observes busy/done and reads HI/LO
    modport master (
        output start_md_i, op_md_i, opr_a_md_i, opr_b_md_i,
        input  busy_md_o, done_md_o, hi_md_o, lo_md_o
    );

    // Unit side
    modport slave (
        input  start_md_i, op_md_i, opr_a_md_i, opr_b_md_i,
        output busy_md_o, done_md_o, hi_md_o, lo_md_o
    );
endinterface
`default_nettype wire

// File: rtl/mult_div.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div
//  Description : Iterative MULT/MULTU/DIV/DIVU unit plus MTHI/MTLO, owning
//                the HI/LO register pair. One shift-add or restoring
//                shift-subtract step per cycle on a 2*DATA_W accumulator,
//                operating on magnitudes with a final sign fixup.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div #(
    parameter int DATA_W = 32
) (
    input  wire logic clk,
    input  wire logic reset,
    mult_div_if.slave md
);

    localparam int                 c_cnt_w = $clog2(DATA_W + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DATA_W - 1);

    typedef enum logic [1:0] {
        c_idle  = 2'd0,
        c_run   = 2'd1,
        c_fixup = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_is_div;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_div0;
    logic [DATA_W-1:0]   r_opnd;     // multiplicand (mul) or divisor (div) magnitude
    logic [2*DATA_W-1:0] r_acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic                r_done;

    // Operand decode and magnitude conversion (op[0]=0 selects the signed form)
    logic              w_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;

    assign w_signed = ~md.op_md_i[0];
    assign w_a_neg  = w_signed & md.opr_a_md_i[DATA_W-1];
    assign w_b_neg  = w_signed & md.opr_b_md_i[DATA_W-1];
    assign w_a_mag  = w_a_neg ? -md.opr_a_md_i : md.opr_a_md_i;
    assign w_b_mag  = w_b_neg ? -md.opr_b_md_i : md.opr_b_md_i;

    // Iteration datapath
    logic [DATA_W:0]     w_mul_sum;
    logic [DATA_W:0]     w_div_diff;
    logic [2*DATA_W-1:0] w_step;

    assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_div_diff = r_acc[2*DATA_W-1:DATA_W-1] - {1'b0, r_opnd};
    // A borrow out of the trial subtraction means "restore": shift in a 0 quotient bit
    assign w_step = !r_is_div    ? {w_mul_sum, r_acc[DATA_W-1:1]} :
                    w_div_diff[DATA_W] ? {r_acc[2*DATA_W-2:0], 1'b0} :
                                         {w_div_diff[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};

    // Sign fixup
    logic [2*DATA_W-1:0] w_prod_fix;
    logic [DATA_W-1:0]   w_quot_fix;
    logic [DATA_W-1:0]   w_rem_fix;

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quot_fix = r_neg_q ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    assign w_rem_fix  = r_neg_r ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

    // Control FSM, iteration state and HI/LO register pair
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_idle;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (md.start_md_i) begin
                        if (!md.op_md_i[2]) begin
                            r_is_div <= md.op_md_i[1];
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_div0   <= md.op_md_i[1] && (md.opr_b_md_i == '0);
                            r_cnt    <= '0;
                            r_state  <= c_run;
                            if (md.op_md_i[1]) begin
                                r_acc  <= {{DATA_W{1'b0}}, w_a_mag};
                                r_opnd <= w_b_mag;
                            end else begin
                                r_acc  <= {{DATA_W{1'b0}}, w_b_mag};
                                r_opnd <= w_a_mag;
                            end
                        end else if (md.op_md_i == 3'b100) begin
                            r_hi <= md.opr_a_md_i;
                        end else if (md.op_md_i == 3'b101) begin
                            r_lo <= md.opr_a_md_i;
                        end
                    end
                end
                c_run: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state <= c_fixup;
                    end
                end
                c_fixup: begin
                    if (r_div0) begin
                        // With a zero divisor every trial subtract succeeds, so the
                        // remainder is |a|; the neg_r fixup restores a as issued.
                        r_lo <= '1;
                        r_hi <= w_rem_fix;
                    end else if (r_is_div) begin
                        r_lo <= w_quot_fix;
                        r_hi <= w_rem_fix;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                    r_done  <= 1'b1;
                    r_state <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign md.busy_md_o = (r_state != c_idle);
    assign md.done_md_o = r_done;
    assign md.hi_md_o   = r_hi;
    assign md.lo_md_o   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div
//  Description : Self-checking bench for mult_div: arithmetic reference model
//                compared every cycle, plus hand-computed directed results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div;

    localparam int DATA_W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cycles;

    mult_div_if #(.DATA_W(DATA_W)) md_if();

    mult_div #(.DATA_W(DATA_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {hi, lo} from plain arithmetic
    function automatic logic [63:0] model_result(input logic [2:0] op,
                                                  input logic [31:0] a,
                                                  input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'b000: begin sq = sa * sb; p = sq; end
            3'b001: p = ua * ub;
            3'b010: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {ub[31:0] == 0 ? 32'd0 : 32'(ua % ub), 32'(ua / ub)};
            end
        endcase
        return p;
    endfunction

    // Behavioural model: an accepted mul/div is busy for DATA_W+1 cycles, then
    // publishes its result with a one-cycle done; MTHI/MTLO write immediately.
    int          m_cnt  = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [63:0] m_res  = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_done <= 1'b1;
                end
            end else if (md_if.start_md_i) begin
                if (!md_if.op_md_i[2]) begin
                    m_res <= model_result(md_if.op_md_i, md_if.opr_a_md_i, md_if.opr_b_md_i);
                    m_cnt <= DATA_W + 1;
                end else if (md_if.op_md_i == 3'b100) begin
                    m_hi <= md_if.opr_a_md_i;
                end else if (md_if.op_md_i == 3'b101) begin
                    m_lo <= md_if.opr_a_md_i;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        check("busy", 64'(md_if.busy_md_o), 64'(m_cnt != 0));
        check("done", 64'(md_if.done_md_o), 64'(m_done));
        check("hi",   64'(md_if.hi_md_o),   64'(m_hi));
        check("lo",   64'(md_if.lo_md_o),   64'(m_lo));
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md_if.op_md_i    = op;
        md_if.opr_a_md_i = a;
        md_if.opr_b_md_i = b;
        md_if.start_md_i = 1'b1;
        @(posedge clk);
        #1;
        md_if.start_md_i = 1'b0;
        md_if.opr_a_md_i = 32'hDEAD_BEEF;
        md_if.opr_b_md_i = 32'hDEAD_BEEF;
    endtask

    // Returns at the negedge inside the done cycle
    task automatic wait_done(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        bit seen = 0;
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md_if.busy_md_o) busy_cycles++;
            if (md_if.done_md_o) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
        end
        check({name, "_hi"}, 64'(md_if.hi_md_o), 64'(exp_hi));
        check({name, "_lo"}, 64'(md_if.lo_md_o), 64'(exp_lo));
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(op, a, b);
        wait_done(name, exp_hi, exp_lo);
        check({name, "_busy_cycles"}, 64'(busy_cycles), 64'd33);
    endtask

    initial begin
        md_if.start_md_i = 1'b0;
        md_if.op_md_i    = 3'b110;
        md_if.opr_a_md_i = '0;
        md_if.opr_b_md_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(md_if.busy_md_o), 64'd0);
        check("rst_done", 64'(md_if.done_md_o), 64'd0);
        check("rst_hi",   64'(md_if.hi_md_o),   64'd0);
        check("rst_lo",   64'(md_if.lo_md_o),   64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed vectors; consecutive run_op calls issue back-to-back
        run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_m3x7", 3'b000, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_min2", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div_m7d2",  3'b010, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_7d2",  3'b011, 32'd7,         32'd2,         32'd1,         32'd3);
        run_op("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_by0",  3'b011, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div_m5by0", 3'b010, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // No-op opcode leaves HI/LO alone
        issue(3'b110, 32'h1111_1111, 32'h2222_2222);
        @(negedge clk);
        check("nop_hi", 64'(md_if.hi_md_o), 64'h0000_0000_FFFF_FFFB);

        // MTHI then MTLO on consecutive edges
        issue(3'b100, 32'h0000_1234, 32'd0);
        issue(3'b101, 32'h0000_5678, 32'd0);
        @(negedge clk);
        check("mthi", 64'(md_if.hi_md_o),   64'h1234);
        check("mtlo", 64'(md_if.lo_md_o),   64'h5678);
        check("mt_busy", 64'(md_if.busy_md_o), 64'd0);

        // Moves issued while a MULT is in flight are ignored
        @(posedge clk);
        #1;
        issue(3'b000, 32'd5, 32'hFFFF_FFFC);
        issue(3'b100, 32'h0000_AAAA, 32'd0);
        issue(3'b101, 32'h0000_BBBB, 32'd0);
        wait_done("mult_mt_ignored", 32'hFFFF_FFFF, 32'hFFFF_FFEC);

        // Reset around cycle 10 of a DIV
        @(posedge clk);
        #1;
        issue(3'b010, 32'h0000_1000, 32'd3);
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", 64'(md_if.busy_md_o), 64'd0);
        check("midrst_done", 64'(md_if.done_md_o), 64'd0);
        check("midrst_hi",   64'(md_if.hi_md_o),   64'd0);
        check("midrst_lo",   64'(md_if.lo_md_o),   64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        run_op("multu_6x7", 3'b001, 32'd6, 32'd7, 32'd0, 32'd42);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
